// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared constants, pointer type and flag helpers for the sync_fifo block.
//   DATA_W_DEF / DEPTH_DEF : default word width and entry count
//   ptr_t                  : read/write pointer (address bits + wrap bit)
//   ptr_empty / ptr_full   : status compares on a pair of pointers
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 8;
  localparam int PTR_W_DEF  = $clog2(DEPTH_DEF);

  typedef logic [PTR_W_DEF:0] ptr_t;

  // Pointers are passed zero-extended to 32 bits so the helpers work for any
  // DEPTH; ptr_w is the number of address bits, bit ptr_w is the wrap bit.
  function automatic logic ptr_empty(input logic [31:0] wptr,
                                     input logic [31:0] rptr);
    return (wptr == rptr);
  endfunction

  function automatic logic ptr_full(input logic [31:0] wptr,
                                    input logic [31:0] rptr,
                                    input int          ptr_w);
    logic [31:0] addr_mask;
    addr_mask = (32'd1 << ptr_w) - 32'd1;
    return ((wptr & addr_mask) == (rptr & addr_mask)) &&
           (wptr[ptr_w] != rptr[ptr_w]);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// -----------------------------------------------------------------------------
// sync_fifo_mem
// DEPTH x DATA_W register array with one write port and a registered read
// port. Array contents are never reset; only the read register is.
//   clk    : rising-edge clock
//   rst    : asynchronous active-low reset of r_data
//   w_en   : store w_data at w_addr on the edge
//   w_addr : write address
//   w_data : write data
//   r_en   : load r_data from r_addr on the edge
//   r_addr : read address
//   r_data : registered read data (holds when r_en=0)
// -----------------------------------------------------------------------------
module sync_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic [PTR_W-1:0]  w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_en,
  input  logic [PTR_W-1:0]  r_addr,
  output logic [DATA_W-1:0] r_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (w_en) begin
      mem[w_addr] <= w_data;
    end
  end

  // Read register: a same-edge write to r_addr is not visible here, so a word
  // can only be popped on the edge after the one that stored it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= '0;
    end else if (r_en) begin
      r_data <= mem[r_addr];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered read data and full/empty flags.
// Optional status outputs are built when SYNC_FIFO_STATUS_EN is defined.
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset (0 resets, 1 runs)
//   w_en      : write request, accepted when not full
//   r_en      : read request, accepted when not empty
//   data_in   : write data
//   data_out  : registered read data, holds when no read is accepted
//   full      : DEPTH words stored
//   empty     : no words stored
//   overflow  : (SYNC_FIFO_STATUS_EN) sticky, write attempted while full
//   underflow : (SYNC_FIFO_STATUS_EN) sticky, read attempted while empty
//   count     : (SYNC_FIFO_STATUS_EN) words stored, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic              r_en,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty
`ifdef SYNC_FIFO_STATUS_EN
  ,
  output logic                   overflow,
  output logic                   underflow,
  output logic [$clog2(DEPTH):0] count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  logic [PTR_W:0] wptr;
  logic [PTR_W:0] rptr;
  logic           wr_acc;
  logic           rd_acc;

  // Flags come straight from the registered pointers; the wrap bit tells a
  // full buffer apart from an empty one when the address bits match.
  assign empty  = ptr_empty(32'(wptr), 32'(rptr));
  assign full   = ptr_full(32'(wptr), 32'(rptr), PTR_W);

  // Both requests are qualified by the pre-edge flags, so a write into a full
  // FIFO is dropped even when a read frees a slot on the same edge.
  assign wr_acc = w_en & ~full;
  assign rd_acc = r_en & ~empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + PTR_ONE;
      if (rd_acc) rptr <= rptr + PTR_ONE;
    end
  end

  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .w_en   (wr_acc),
    .w_addr (wptr[PTR_W-1:0]),
    .w_data (data_in),
    .r_en   (rd_acc),
    .r_addr (rptr[PTR_W-1:0]),
    .r_data (data_out)
  );

`ifdef SYNC_FIFO_STATUS_EN
  assign count = wptr - rptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_en && full)  overflow  <= 1'b1;
      if (r_en && empty) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo
// Directed bench for sync_fifo: a vector table for reset, fill/drain and
// steady-state read/write, plus hand sequences for concurrent streams,
// write-while-full and asynchronous reset. Status outputs are checked when
// SYNC_FIFO_STATUS_EN is defined.
// -----------------------------------------------------------------------------
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       w_en;
  logic       r_en;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
`ifdef SYNC_FIFO_STATUS_EN
  logic       overflow;
  logic       underflow;
  logic [3:0] count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  sync_fifo #(.DATA_W(8), .DEPTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .w_en     (w_en),
    .r_en     (r_en),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
`ifdef SYNC_FIFO_STATUS_EN
    ,
    .overflow (overflow),
    .underflow(underflow),
    .count    (count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       w;
    logic       r;
    logic [7:0] din;
    logic [7:0] dout;
    logic       full;
    logic       empty;
    int         cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic w, input logic r, input logic [7:0] din,
                     input logic [7:0] dout, input logic f, input logic e,
                     input int cnt);
    vec_t v;
    v.w = w; v.r = r; v.din = din; v.dout = dout;
    v.full = f; v.empty = e; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  // Drive one set of requests, let one rising edge pass, sample 1 ns later.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    w_en = w; r_en = r; data_in = d;
    @(posedge clk);
    #1;
  endtask

  // Queue model for the random concurrent-stream sequence.
  logic [7:0] model_q[$];
  logic [7:0] model_dout;

  task automatic model_cyc(input logic w, input logic r, input logic [7:0] d);
    logic m_full, m_empty;
    m_full  = (model_q.size() == 8);
    m_empty = (model_q.size() == 0);
    if (r && !m_empty) model_dout = model_q.pop_front();
    if (w && !m_full)  model_q.push_back(d);
    cyc(w, r, d);
    chk("stream_dout",  int'(data_out), int'(model_dout));
    chk("stream_empty", int'(empty),    int'(model_q.size() == 0));
    chk("stream_full",  int'(full),     int'(model_q.size() == 8));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Vector table: reset read, fill, dropped write, drain, half-occupancy
    // streaming with pointer wrap, final drain.
    add(1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 0);
    for (int i = 0; i < 8; i++) add(1'b1, 1'b0, 8'(8'h11 + i), 8'h00, 1'(i == 7), 1'b0, i + 1);
    add(1'b1, 1'b0, 8'hAA, 8'h00, 1'b1, 1'b0, 8);
    for (int i = 0; i < 8; i++) add(1'b0, 1'b1, 8'h00, 8'(8'h11 + i), 1'b0, 1'(i == 7), 7 - i);
    for (int i = 0; i < 4; i++) add(1'b1, 1'b0, 8'(8'h21 + i), 8'h18, 1'b0, 1'b0, i + 1);
    for (int i = 0; i < 12; i++) add(1'b1, 1'b1, 8'(8'h25 + i), 8'(8'h21 + i), 1'b0, 1'b0, 4);
    for (int i = 0; i < 4; i++) add(1'b0, 1'b1, 8'h00, 8'(8'h2D + i), 1'b0, 1'(i == 3), 3 - i);

    w_en = 1'b0; r_en = 1'b0; data_in = 8'h00;
    rst = 1'b0;
    #7;
    rst = 1'b1;
    chk("reset_empty", int'(empty),    1);
    chk("reset_full",  int'(full),     0);
    chk("reset_dout",  int'(data_out), 0);
`ifdef SYNC_FIFO_STATUS_EN
    chk("reset_count", int'(count), 0);
    chk("reset_ovf",   int'(overflow), 0);
`endif

    foreach (vecs[i]) begin
      cyc(vecs[i].w, vecs[i].r, vecs[i].din);
      chk($sformatf("vec%0d_dout", i),  int'(data_out), int'(vecs[i].dout));
      chk($sformatf("vec%0d_full", i),  int'(full),     int'(vecs[i].full));
      chk($sformatf("vec%0d_empty", i), int'(empty),    int'(vecs[i].empty));
`ifdef SYNC_FIFO_STATUS_EN
      chk($sformatf("vec%0d_count", i), int'(count), vecs[i].cnt);
`endif
    end
`ifdef SYNC_FIFO_STATUS_EN
    chk("table_ovf", int'(overflow),  1);
    chk("table_unf", int'(underflow), 1);
`endif

    // Concurrent streams: writes on cycles 0..9, reads on cycles 2..11.
    model_dout = 8'h30;
    for (int c = 0; c < 12; c++) begin
      model_cyc(1'(c < 10), 1'(c >= 2), 8'($urandom_range(255)));
    end
    chk("stream_left", model_q.size(), 0);

    // Full plus simultaneous read: the read pops, the write is dropped.
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'(8'h41 + i));
    chk("fill2_full", int'(full), 1);
    cyc(1'b1, 1'b1, 8'h5A);
    chk("fullrw_dout",  int'(data_out), 8'h41);
    chk("fullrw_full",  int'(full),     0);
    chk("fullrw_empty", int'(empty),    0);
`ifdef SYNC_FIFO_STATUS_EN
    chk("fullrw_ovf",   int'(overflow), 1);
    chk("fullrw_count", int'(count),    7);
`endif
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      chk($sformatf("drain2_%0d", i), int'(data_out), int'(8'(8'h42 + i)));
    end
    chk("drain2_empty", int'(empty), 1);
    cyc(1'b0, 1'b1, 8'h00);
    chk("drain2_hold", int'(data_out), 8'h48);

    // Asynchronous reset mid-cycle with 3 words stored.
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'(8'h61 + i));
    cyc(1'b0, 1'b1, 8'h00);
    chk("pre_arst_dout", int'(data_out), 8'h61);
    w_en = 1'b0; r_en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_empty", int'(empty),    1);
    chk("arst_full",  int'(full),     0);
    chk("arst_dout",  int'(data_out), 0);
`ifdef SYNC_FIFO_STATUS_EN
    chk("arst_count", int'(count),     0);
    chk("arst_ovf",   int'(overflow),  0);
    chk("arst_unf",   int'(underflow), 0);
`endif
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b0, 1'b1, 8'h00);
    chk("post_arst_dout",  int'(data_out), 0);
    chk("post_arst_empty", int'(empty),    1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
